// File: rtl/fp32_isqrt_operand_prep.sv
// fp32_isqrt_operand_prep: unpack and classify an fp32 operand into mantissa, half-exponent and special result for the rsqrt core
// CLK, RST, CE: clock, synchronous active-high reset, clock enable
// in_valid, in_ready, in_data: operand handshake and IEEE-754 single operand
// out_valid, out_ready: result handshake; out_mant: 1.(WL-1) mantissa; out_hexp: signed -h
// out_odd: exponent is odd; out_special, out_spec_val: bypass result for special operands
module fp32_isqrt_operand_prep #(
  parameter int WL = 24,
  parameter int EW = 9,
  parameter bit SUBN_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_mant,
  output logic [EW-1:0] out_hexp,
  output logic          out_odd,
  output logic          out_special,
  output logic [31:0]   out_spec_val
);
  typedef enum logic {IDLE, NORM} state_t;
  state_t state;
  logic [22:0] sr, frac;
  logic [23:0] shifted, m_sel;
  logic [7:0] ex;
  logic signed [9:0] e, e_in, e_sel, nh;
  logic sign, is_nan, is_zero, pos_sub, special, accept, consumed, load, spec_ld;
  logic [31:0] spec_val;
  logic [WL-1:0] one, m_ext;
  assign sign = in_data[31];
  assign ex = in_data[30:23];
  assign frac = in_data[22:0];
  assign is_nan = &ex & |frac;
  // with SUBN_EN=0 a subnormal is classified as a zero of the same sign
  assign is_zero = ~|ex & (~|frac | ~SUBN_EN);
  assign pos_sub = ~|ex & |frac & SUBN_EN & ~sign;
  assign special = is_nan | is_zero | sign | &ex;
  assign spec_val = is_nan ? {sign, 8'hFF, 1'b1, frac[21:0]} :
                    is_zero ? {sign, 8'hFF, 23'd0} :
                    sign ? 32'h7FC00000 : 32'h0;
  assign in_ready = CE & ~RST & (state == IDLE) & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign consumed = out_valid & out_ready & CE;
  assign shifted = {sr, 1'b0};
  assign e_in = $signed({2'b00, ex}) - 10'sd127;
  // the same split/load path serves both the direct and the normalised operand
  assign e_sel = (state == NORM) ? e - 10'sd1 : e_in;
  assign m_sel = (state == NORM) ? shifted : {1'b1, frac};
  assign nh = -(e_sel >>> 1);
  assign load = (state == NORM) ? shifted[23] : accept & ~pos_sub;
  assign spec_ld = (state == IDLE) & special;
  assign one = {1'b1, {(WL-1){1'b0}}};
  assign m_ext = WL'(m_sel) << (WL - 24);
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_mant <= '0;
      out_hexp <= '0;
      out_odd <= 1'b0;
      out_special <= 1'b0;
      out_spec_val <= '0;
      sr <= '0;
      e <= '0;
    end else if (CE) begin
      if (consumed) out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_mant <= spec_ld ? one : m_ext;
        out_hexp <= spec_ld ? '0 : EW'(nh);
        out_odd <= ~spec_ld & e_sel[0];
        out_special <= spec_ld;
        out_spec_val <= spec_ld ? spec_val : '0;
      end
      if (state == NORM) begin
        sr <= shifted[22:0];
        e <= e_sel;
        if (shifted[23]) state <= IDLE;
      end else if (accept & pos_sub) begin
        sr <= frac;
        e <= -10'sd126;
        state <= NORM;
      end
    end
endmodule

// File: tb/tb_fp32_isqrt_operand_prep.sv
// tb_fp32_isqrt_operand_prep: directed self-checking bench for fp32_isqrt_operand_prep
module tb_fp32_isqrt_operand_prep;
  logic CLK, RST, CE, in_valid, in_ready, out_valid, out_ready, out_odd, out_special, seen;
  logic [31:0] in_data, out_spec_val;
  logic [23:0] out_mant;
  logic [8:0] out_hexp;
  int checks, errors, n;
  logic [31:0] nd [5] = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F000000, 32'h3FC00000};
  logic [23:0] nm [5] = '{24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'hC00000};
  logic [8:0] nhx [5] = '{9'h000, 9'h1FF, 9'h000, 9'h001, 9'h000};
  logic no [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] sd [6] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hBF800000, 32'h7F800001, 32'h80000001};
  logic [31:0] sv [6] = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00001, 32'h7FC00000};
  fp32_isqrt_operand_prep dut (
    .CLK(CLK), .RST(RST), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_hexp(out_hexp), .out_odd(out_odd),
    .out_special(out_special), .out_spec_val(out_spec_val)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask
  task automatic res(input string tag, input logic [23:0] m, input logic [8:0] h, input logic o, input logic s, input logic [31:0] v);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mant"}, 32'(out_mant), 32'(m));
    chk({tag, "_hexp"}, 32'(out_hexp), 32'(h));
    chk({tag, "_odd"}, 32'(out_odd), 32'(o));
    chk({tag, "_special"}, 32'(out_special), 32'(s));
    chk({tag, "_specval"}, out_spec_val, v);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    CE = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_mant", 32'(out_mant), 32'd0);
    chk("rst_hexp", 32'(out_hexp), 32'd0);
    chk("rst_special", 32'(out_special), 32'd0);
    chk("rst_specval", out_spec_val, 32'd0);
    RST = 1'b0;
    #1 chk("idle_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = nd[i];
      @(negedge CLK);
      res($sformatf("normal%0d", i), nm[i], nhx[i], no[i], 1'b0, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      in_data = sd[i];
      @(negedge CLK);
      res($sformatf("special%0d", i), 24'h800000, 9'h000, 1'b0, 1'b1, sv[i]);
    end
    in_valid = 1'b0;
    @(negedge CLK);
    chk("drain_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h00400000;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("sub1_ready_norm", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("sub1_latency", 32'(n), 32'd1);
    res("sub1", 24'h800000, 9'h040, 1'b1, 1'b0, 32'h0);
    in_valid = 1'b1;
    in_data = 32'h00000001;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("sub2_ready_norm", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("sub2_latency", 32'(n), 32'd23);
    res("sub2", 24'h800000, 9'h04B, 1'b1, 1'b0, 32'h0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h3F000000;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hexp", 32'(out_hexp), 32'h04B);
      chk("bp_mant", 32'(out_mant), 32'h800000);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    res("bp_next", 24'h800000, 9'h001, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    chk("bp_drain", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h00000001;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstnorm_valid", 32'(out_valid), 32'd0);
    chk("rstnorm_ready", 32'(in_ready), 32'd0);
    RST = 1'b0;
    #1 chk("rstnorm_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    @(negedge CLK);
    in_valid = 1'b0;
    res("post_rst", 24'h800000, 9'h000, 1'b0, 1'b0, 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      seen = seen | out_valid;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h00000001;
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge CLK);
      n++;
      CE = !(n >= 5 && n < 8);
      if (!CE) chk("ce_ready", 32'(in_ready), 32'd0);
    end
    CE = 1'b1;
    chk("ce_latency", 32'(n), 32'd26);
    res("ce_sub", 24'h800000, 9'h04B, 1'b1, 1'b0, 32'h0);
    CE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("ce_hold_valid", 32'(out_valid), 32'd1);
    chk("ce_hold_hexp", 32'(out_hexp), 32'h04B);
    CE = 1'b1;
    @(negedge CLK);
    chk("ce_release_drain", 32'(out_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp32_isqrt_operand_prep.md
Name: fp32_isqrt_operand_prep

Overview:
Front-end stage for the reciprocal square-root core. It unpacks an IEEE-754 single-precision operand and classifies it, then produces the 1.x mantissa the core takes on its din, plus sideband data that the post-stage uses to rebuild the result. Subnormals are normalised iteratively, one bit per cycle. Handshake is valid/ready on both sides, with a single output register.

Parameters:
WL, 24, mantissa output width in 1.(WL-1) format. Must be at least 24. The fraction is left-aligned and zero-padded below.
EW, 9, width of the signed half-exponent output (two's complement).
SUBN_EN, 1, 1 = normalise subnormals; 0 = flush subnormals to a signed zero.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
CE  in  1  clock enable; when 0 all registers hold and no transfer occurs
in_valid  in  1  input operand valid
in_ready  out  1  stage can accept an operand
in_data  in  32  IEEE-754 single
out_valid  out  1  output register holds a result
out_ready  in  1  downstream accepts
out_mant  out  WL  normalised mantissa m in [1,2), 1.(WL-1) format; drives the core's din
out_hexp  out  EW  signed -h, where operand exponent E = 2h + odd
out_odd  out  1  E is odd; post-stage must scale by 2^-0.5
out_special  out  1  result is out_spec_val; the core result is ignored
out_spec_val  out  32  IEEE result for special operands

Behaviour:
- Reset (RST=1 at an edge): state=IDLE. out_valid, out_mant, out_hexp, out_odd, out_special and out_spec_val all clear to 0. in_ready=0 while RST=1. A reset mid-NORM abandons the operand.
- in_ready = CE & ~RST & (state!=NORM) & (~out_valid | out_ready). This is combinational.
- Accept = in_valid & in_ready. Output consumed = out_valid & out_ready & CE. The consumed flag clears out_valid unless a result loads on the same edge.
- Unbiased exponent: E = exp-127 for normals; E = -126 for subnormals before normalisation.
- Split: h = floor(E/2) (arithmetic shift); odd = E[0]; out_hexp = -h.
- Normal operand (exp 1..254, sign 0): output is loaded on the accept edge, so latency is 1.
  - out_mant = {1, frac, zeros}; out_special = 0.
- Special operands are loaded on the accept edge, with out_special=1, out_mant=1.0, out_hexp=0, out_odd=0:
  - NaN → {sign, 8'hFF, 1, frac[21:0]}.
  - Negative nonzero (including -inf and negative subnormal) → 0x7FC00000.
  - +0 → 0x7F800000.
  - -0 → 0xFF800000.
  - +inf → 0x00000000.
  - When SUBN_EN=0, a subnormal is treated as a zero of the same sign.
- Positive subnormal with SUBN_EN=1: the accept edge loads the shift register with {0, frac} and sets E=-126, then enters NORM.
  - Each NORM edge shifts left by 1 and decrements E.
  - On the edge where the shifted value has its MSB set, the output loads, out_valid=1 and state returns to IDLE.
  - With z = leading zeros of frac[22:0], NORM lasts z+1 edges, so out_valid rises z+1 edges after the accept edge.
- States: IDLE (accept, or hold the output) → NORM on a subnormal accept; NORM → IDLE on normalisation complete. out_valid is 0 throughout NORM.
- Throughput: one operand per cycle for normal and special operands while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and all outputs hold stable.
- CE=0: no state change; outputs hold; in_ready=0.
- No overflow is possible: out_hexp lies in [-63, 75].

Test Plan:
- Normal operands back-to-back with out_ready=1:
  - 0x3F800000 → mant 0x800000, hexp 0, odd 0.
  - 0x40800000 → hexp 0x1FF (-1), odd 0.
  - 0x40000000 → hexp 0, odd 1.
  - 0x3F000000 → hexp 1, odd 1.
  - Expect one result per cycle, each 1 cycle after accept.
- Special operands:
  - 0x00000000 → 0x7F800000.
  - 0x80000000 → 0xFF800000.
  - 0x7F800000 → 0x00000000.
  - 0xBF800000 → 0x7FC00000.
  - 0x7F800001 → 0x7FC00001.
  - All with out_special=1 and latency 1.
- Subnormals:
  - 0x00400000 → mant 0x800000, hexp 64, odd 1; out_valid 1 edge after accept; in_ready low during NORM.
  - 0x00000001 → mant 0x800000, hexp 75, odd 1; latency 23 edges.
- Backpressure: hold out_ready=0 for 5 cycles after a result. Expect outputs stable and in_ready=0; release → next operand accepted on the same edge the result is consumed.
- RST asserted on the 10th NORM edge of 0x00000001 → out_valid=0 and state=IDLE. A following 0x3F800000 completes normally.
- CE toggling during NORM: CE=0 for 3 cycles freezes the shift count, so total latency increases by exactly 3.
